// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared states, grant codes and counter width for mem_responder
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PTR    = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic GNT_INSTR = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - 2^ADDR_W x DATA_W storage, async read, sync write
module mem_resp_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately never reset; a write lands on the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - req/ack memory responder with wait states; MEM_RESPONDER_INDIRECT_EN enables indirect data access
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_ind,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              gnt_port;
  logic              last_grant;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              arr_we;
  logic              grant;
  logic              grant_port;
  logic              grant_ind;
  logic              cnt_zero;

`ifdef MEM_RESPONDER_INDIRECT_EN
  assign grant_ind = d_ind;
`else
  logic d_ind_unused;
  assign d_ind_unused = d_ind;
  assign grant_ind    = 1'b0;
`endif

  assign cnt_zero = (cnt == '0);
  assign arr_we   = (state == ACCESS) && cnt_zero && we;

  mem_resp_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (addr),
    .wdata(wdata),
    .rdata(mem_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Round-robin grant decision in IDLE and next-state selection.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_port = GNT_INSTR;
    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          grant      = 1'b1;
          grant_port = ~last_grant;
        end else if (i_req) begin
          grant      = 1'b1;
          grant_port = GNT_INSTR;
        end else if (d_req) begin
          grant      = 1'b1;
          grant_port = GNT_DATA;
        end
        if (grant) begin
          state_next = ((grant_port == GNT_DATA) && grant_ind) ? PTR : ACCESS;
        end
      end
`ifdef MEM_RESPONDER_INDIRECT_EN
      PTR: begin
        if (cnt_zero) begin
          state_next = ACCESS;
        end
      end
`endif
      ACCESS: begin
        if (cnt_zero) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, wait counter, pointer fetch and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      gnt_port   <= GNT_INSTR;
      last_grant <= GNT_DATA;
      addr       <= '0;
      we         <= 1'b0;
      wdata      <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (grant) begin
        gnt_port   <= grant_port;
        last_grant <= grant_port;
        addr       <= (grant_port == GNT_DATA) ? d_addr : i_addr;
        we         <= (grant_port == GNT_DATA) && d_we;
        wdata      <= d_wdata;
        cnt        <= WAIT_LOAD;
      end else if (state == PTR || state == ACCESS) begin
        if (!cnt_zero) begin
          cnt <= cnt - 1'b1;
        end else if (state == PTR) begin
          // Pointer word is truncated: high bits simply wrap the address.
          addr <= mem_rdata[ADDR_W-1:0];
          cnt  <= WAIT_LOAD;
        end else if (gnt_port == GNT_INSTR) begin
          i_ack   <= 1'b1;
          i_rdata <= mem_rdata;
        end else begin
          d_ack <= 1'b1;
          if (!we) begin
            d_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized model-checked bench for mem_responder
module tb_mem_responder;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int WC = 2;

`ifdef MEM_RESPONDER_INDIRECT_EN
  localparam bit IND_EN = 1'b1;
`else
  localparam bit IND_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic          d_ind = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_ind(d_ind), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction-level reference: one request in service, fixed latency,
  // one dead cycle after completion, round-robin on ties.
  logic [DW-1:0] mm [1024];
  bit            m_busy, m_cool, m_port, m_we, m_ind, last;
  int            m_rem;
  logic [AW-1:0] m_addr, eff;
  logic [DW-1:0] m_wdata;
  logic          e_iack, e_dack;
  logic [DW-1:0] e_ird, e_drd;
  bit            ack_log [$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_cool = 0; last = 1;
      e_iack = 0; e_dack = 0; e_ird = '0; e_drd = '0;
    end else begin
      e_iack = 0; e_dack = 0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          if (!m_port) begin
            e_iack = 1;
            e_ird  = mm[m_addr];
          end else begin
            eff = m_ind ? mm[m_addr][AW-1:0] : m_addr;
            e_dack = 1;
            if (m_we) mm[eff] = m_wdata;
            else      e_drd = mm[eff];
          end
          m_busy = 0;
          m_cool = 1;
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else if (i_req || d_req) begin
        m_port  = (i_req && d_req) ? !last : d_req;
        last    = m_port;
        m_busy  = 1;
        m_addr  = m_port ? d_addr : i_addr;
        m_we    = d_we;
        m_wdata = d_wdata;
        m_ind   = m_port && IND_EN && d_ind;
        m_rem   = m_ind ? 2 * (WC + 1) : WC + 1;
      end
    end
    #1;
    chk("i_ack", i_ack, e_iack);
    chk("d_ack", d_ack, e_dack);
    chk("i_rdata", i_rdata, e_ird);
    chk("d_rdata", d_rdata, e_drd);
    chk("ack_overlap", i_ack & d_ack, 1'b0);
    if (i_ack) ack_log.push_back(1'b0);
    if (d_ack) ack_log.push_back(1'b1);
  end

  task automatic fetch(input logic [AW-1:0] a, output logic [DW-1:0] rd, output int lat);
    bit got = 0;
    @(negedge clk);
    i_addr = a;
    i_req  = 1'b1;
    lat    = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk);
      #2;
      lat++;
      if (i_ack) got = 1;
    end
    rd = i_rdata;
    if (!got) begin
      total++; bad++;
      $display("FAIL fetch_timeout actual=no_ack required=ack");
    end
    @(negedge clk);
    i_req = 1'b0;
  endtask

  task automatic data(input logic [AW-1:0] a, input bit w, input bit ind,
                      input logic [DW-1:0] wd, output logic [DW-1:0] rd, output int lat);
    bit got = 0;
    @(negedge clk);
    d_addr  = a;
    d_we    = w;
    d_ind   = ind;
    d_wdata = wd;
    d_req   = 1'b1;
    lat     = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk);
      #2;
      lat++;
      if (d_ack) got = 1;
    end
    rd = d_rdata;
    if (!got) begin
      total++; bad++;
      $display("FAIL data_timeout actual=no_ack required=ack");
    end
    @(negedge clk);
    d_req = 1'b0;
  endtask

  logic [DW-1:0] rd, exp20, exp21;
  int            lat, exp_ind_lat;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_i_ack", i_ack, 1'b0);
    chk("reset_d_ack", d_ack, 1'b0);
    chk("reset_i_rdata", i_rdata, 16'h0);
    chk("reset_d_rdata", d_rdata, 16'h0);
    rst_n = 1'b1;

    for (int a = 0; a < 1024; a++) begin
      data(AW'(a), 1'b1, 1'b0, DW'($urandom), rd, lat);
    end

    data(10'd5, 1'b1, 1'b0, 16'h1234, rd, lat);
    fetch(10'd5, rd, lat);
    chk("fetch5_data", rd, 16'h1234);
    chk("fetch5_latency", lat, 4);

    data(10'd10, 1'b1, 1'b0, 16'hBEEF, rd, lat);
    chk("write10_latency", lat, 4);
    data(10'd10, 1'b0, 1'b0, 16'h0, rd, lat);
    chk("read10_data", rd, 16'hBEEF);
    chk("read10_latency", lat, 4);

    data(10'd20, 1'b1, 1'b0, 16'h0032, rd, lat);
    data(10'd50, 1'b1, 1'b0, 16'h00AA, rd, lat);
    data(10'd21, 1'b1, 1'b0, 16'hFC32, rd, lat);
`ifdef MEM_RESPONDER_INDIRECT_EN
    exp20 = 16'h00AA; exp21 = 16'h00AA; exp_ind_lat = 7;
`else
    exp20 = 16'h0032; exp21 = 16'hFC32; exp_ind_lat = 4;
`endif
    data(10'd20, 1'b0, 1'b1, 16'h0, rd, lat);
    chk("ind20_data", rd, exp20);
    chk("ind20_latency", lat, exp_ind_lat);
    data(10'd21, 1'b0, 1'b1, 16'h0, rd, lat);
    chk("ind21_wrap_data", rd, exp21);

    @(negedge clk);
`ifdef MEM_RESPONDER_INDIRECT_EN
    d_addr = 10'd20; d_ind = 1'b1;
`else
    d_addr = 10'd50; d_ind = 1'b0;
`endif
    d_we = 1'b1; d_wdata = 16'hDEAD; d_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    chk("midreset_i_ack", i_ack, 1'b0);
    chk("midreset_d_ack", d_ack, 1'b0);
    chk("midreset_i_rdata", i_rdata, 16'h0);
    chk("midreset_d_rdata", d_rdata, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    data(10'd50, 1'b0, 1'b0, 16'h0, rd, lat);
    chk("after_reset_mem50", rd, 16'h00AA);
    chk("after_reset_latency", lat, 4);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_log.delete();
    fork
      begin : tie_i
        logic [DW-1:0] r; int l;
        repeat (2) fetch(10'd7, r, l);
      end
      begin : tie_d
        logic [DW-1:0] r; int l;
        repeat (2) data(10'd8, 1'b0, 1'b0, 16'h0, r, l);
      end
    join
    chk("tie_count", ack_log.size(), 4);
    while (ack_log.size() < 4) ack_log.push_back(1'b0);
    chk("tie_order0", ack_log[0], 1'b0);
    chk("tie_order1", ack_log[1], 1'b1);
    chk("tie_order2", ack_log[2], 1'b0);
    chk("tie_order3", ack_log[3], 1'b1);

    fork
      begin : rnd_i
        logic [DW-1:0] r; int l;
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          fetch(AW'($urandom), r, l);
        end
      end
      begin : rnd_d
        logic [DW-1:0] r; int l;
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          data(AW'($urandom_range(0, 63)), 1'($urandom), 1'($urandom),
               DW'($urandom), r, l);
        end
      end
    join

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
